alu_writeback_stage: RTL and testbench

//  EX->WB pipeline register directly downstream of the 8-bit ALU. Captures the ALU result,

---
 rtl/alu_writeback_stage.sv | 110 +++++++++++
 tb/tb_alu_writeback_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: EX->WB pipeline register with the flag register, the retired-instruction counter and optional forwarding
//
// Optional feature macro: ALU_WB_FWD_EN (define it to build the operand-forwarding compare).
//
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_ex_valid                          EX-stage output belongs to a live instruction
//   i_alu_result                        ALU result
//   i_zero_flag, i_parity_flag,
//   i_not_equal                         ALU flags
//   i_ex_dest, i_ex_reg_wr, i_ex_flag_wr  destination register and write controls
//   i_stall                             hold all WB-stage state
//   i_flush                             squash the EX instruction
//   i_src_a_addr, i_src_b_addr          ALU operand register addresses (forwarding compare)
//   o_wb_en, o_wb_addr, o_wb_data       register-file write port
//   o_flag_z, o_flag_p, o_flag_ne       architectural flags
//   o_fwd_a_hit, o_fwd_b_hit            select wb data for ALU input_0 / input_1
//   o_retired                           count of captured valid instructions
module alu_writeback_stage #(
   parameter int REG_AW = 3,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ex_valid,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic              i_zero_flag,
   input  logic              i_parity_flag,
   input  logic              i_not_equal,
   input  logic [REG_AW-1:0] i_ex_dest,
   input  logic              i_ex_reg_wr,
   input  logic              i_ex_flag_wr,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [REG_AW-1:0] i_src_a_addr,
   input  logic [REG_AW-1:0] i_src_b_addr,
   output logic              o_wb_en,
   output logic [REG_AW-1:0] o_wb_addr,
   output logic [DATA_W-1:0] o_wb_data,
   output logic              o_flag_z,
   output logic              o_flag_p,
   output logic              o_flag_ne,
   output logic              o_fwd_a_hit,
   output logic              o_fwd_b_hit,
   output logic [CNT_W-1:0]  o_retired
);
   logic              r_wb_valid;
   logic              r_wb_reg_wr;
   logic [REG_AW-1:0] r_wb_addr;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_flag_z;
   logic              r_flag_p;
   logic              r_flag_ne;
   logic [CNT_W-1:0]  r_retired;
   logic              w_cap;
   logic              w_wb_en;

   assign w_cap   = i_ex_valid & ~i_stall & ~i_flush;
   assign w_wb_en = r_wb_valid & r_wb_reg_wr;

   // flush outranks stall; a stall holds everything so the pending write is re-presented
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wb_valid  <= 1'b0;
         r_wb_reg_wr <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_flag_z    <= 1'b0;
         r_flag_p    <= 1'b0;
         r_flag_ne   <= 1'b0;
         r_retired   <= '0;
      end else if (i_flush) begin
         r_wb_valid  <= 1'b0;
         r_wb_reg_wr <= 1'b0;
      end else if (!i_stall) begin
         r_wb_valid <= i_ex_valid;
         if (w_cap) begin
            r_wb_reg_wr <= i_ex_reg_wr;
            r_wb_addr   <= i_ex_dest;
            r_wb_data   <= i_alu_result;
            r_retired   <= r_retired + 1'b1;
            if (i_ex_flag_wr) begin
               r_flag_z  <= i_zero_flag;
               r_flag_p  <= i_parity_flag;
               r_flag_ne <= i_not_equal;
            end
         end
      end
   end

   assign o_wb_en   = w_wb_en;
   assign o_wb_addr = r_wb_addr;
   assign o_wb_data = r_wb_data;
   assign o_flag_z  = r_flag_z;
   assign o_flag_p  = r_flag_p;
   assign o_flag_ne = r_flag_ne;
   assign o_retired = r_retired;

`ifdef ALU_WB_FWD_EN
   assign o_fwd_a_hit = w_wb_en & (r_wb_addr == i_src_a_addr);
   assign o_fwd_b_hit = w_wb_en & (r_wb_addr == i_src_b_addr);
`else
   // without forwarding, control bubbles RAW hazards and the operand addresses go unused
   logic w_unused_src;
   assign w_unused_src = ^{i_src_a_addr, i_src_b_addr};
   assign o_fwd_a_hit  = 1'b0;
   assign o_fwd_b_hit  = 1'b0;
`endif
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: vector table plus scoreboard bench for alu_writeback_stage
module tb_alu_writeback_stage;
   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] res;
      logic       z;
      logic       p;
      logic       ne;
      logic [2:0] dst;
      logic       rw;
      logic       fw;
      logic       stl;
      logic       fl;
      logic [2:0] sa;
      logic [2:0] sb;
      logic       en;
      logic [2:0] ea;
      logic [7:0] ed;
      logic       ez;
      logic       ep;
      logic       ene;
      logic [15:0] er;
      logic       ad;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, ex_valid, zero_flag, parity_flag, not_equal, ex_reg_wr, ex_flag_wr, stall, flush;
   logic [7:0]  alu_result;
   logic [2:0]  ex_dest, src_a_addr, src_b_addr;
   logic        wb_en, flag_z, flag_p, flag_ne, fwd_a_hit, fwd_b_hit;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic [15:0] retired;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[15];
   vec_t sb_q[$];

   always #5 clk = ~clk;

   alu_writeback_stage dut (
      .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_alu_result(alu_result),
      .i_zero_flag(zero_flag), .i_parity_flag(parity_flag), .i_not_equal(not_equal),
      .i_ex_dest(ex_dest), .i_ex_reg_wr(ex_reg_wr), .i_ex_flag_wr(ex_flag_wr),
      .i_stall(stall), .i_flush(flush), .i_src_a_addr(src_a_addr), .i_src_b_addr(src_b_addr),
      .o_wb_en(wb_en), .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_flag_z(flag_z),
      .o_flag_p(flag_p), .o_flag_ne(flag_ne), .o_fwd_a_hit(fwd_a_hit), .o_fwd_b_hit(fwd_b_hit),
      .o_retired(retired)
   );

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; ex_valid = v.vld; alu_result = v.res; zero_flag = v.z; parity_flag = v.p;
      not_equal = v.ne; ex_dest = v.dst; ex_reg_wr = v.rw; ex_flag_wr = v.fw; stall = v.stl;
      flush = v.fl; src_a_addr = v.sa; src_b_addr = v.sb;
   endtask

   task automatic compare(input int idx);
      vec_t e;
      logic xa, xb;
      e = sb_q.pop_front();
`ifdef ALU_WB_FWD_EN
      xa = e.en & (e.ea == src_a_addr);
      xb = e.en & (e.ea == src_b_addr);
`else
      xa = 1'b0;
      xb = 1'b0;
`endif
      check("wb_en", idx, 16'(wb_en), 16'(e.en));
      if (e.ad) begin
         check("wb_addr", idx, 16'(wb_addr), 16'(e.ea));
         check("wb_data", idx, 16'(wb_data), 16'(e.ed));
      end
      check("flags", idx, 16'({flag_z, flag_p, flag_ne}), 16'({e.ez, e.ep, e.ene}));
      check("retired", idx, retired, e.er);
      check("fwd_a", idx, 16'(fwd_a_hit), 16'(xa));
      check("fwd_b", idx, 16'(fwd_b_hit), 16'(xb));
   endtask

   initial begin
      // rst vld res   z  p  ne dst rw fw st fl sa sb | en ea ed   z  p  ne ret ad
      vecs[0]  = '{1,1,8'h99,0,1,1,3'd1,1,1,0,0,3'd0,3'd0, 0,3'd0,8'h00,0,0,0,16'd0,1};
      vecs[1]  = '{1,1,8'h99,0,1,1,3'd1,1,1,0,0,3'd0,3'd0, 0,3'd0,8'h00,0,0,0,16'd0,1};
      vecs[2]  = '{0,1,8'h5A,0,0,0,3'd3,1,0,0,0,3'd3,3'd1, 1,3'd3,8'h5A,0,0,0,16'd1,1};
      vecs[3]  = '{0,1,8'h00,1,0,0,3'd4,1,1,0,0,3'd4,3'd4, 1,3'd4,8'h00,1,0,0,16'd2,1};
      vecs[4]  = '{0,1,8'h07,0,1,1,3'd5,1,0,0,0,3'd4,3'd5, 1,3'd5,8'h07,1,0,0,16'd3,1};
      vecs[5]  = '{0,1,8'h11,0,0,0,3'd2,1,0,0,0,3'd2,3'd0, 1,3'd2,8'h11,1,0,0,16'd4,1};
      vecs[6]  = '{0,1,8'h22,0,1,1,3'd6,1,1,1,0,3'd1,3'd2, 1,3'd2,8'h11,1,0,0,16'd4,1};
      vecs[7]  = '{0,1,8'h22,0,1,1,3'd6,1,1,1,0,3'd2,3'd1, 1,3'd2,8'h11,1,0,0,16'd4,1};
      vecs[8]  = '{0,1,8'h22,0,1,1,3'd6,1,1,1,0,3'd0,3'd0, 1,3'd2,8'h11,1,0,0,16'd4,1};
      vecs[9]  = '{0,1,8'h22,0,1,1,3'd6,1,1,0,0,3'd6,3'd6, 1,3'd6,8'h22,0,1,1,16'd5,1};
      vecs[10] = '{0,1,8'h33,1,1,1,3'd1,1,1,1,1,3'd1,3'd1, 0,3'd0,8'h00,0,1,1,16'd5,0};
      vecs[11] = '{0,0,8'h44,1,1,1,3'd1,1,1,0,0,3'd1,3'd1, 0,3'd0,8'h00,0,1,1,16'd5,0};
      vecs[12] = '{0,1,8'h44,0,0,0,3'd7,0,1,0,0,3'd7,3'd7, 0,3'd7,8'h44,0,0,0,16'd6,1};
      vecs[13] = '{0,1,8'hAB,1,1,1,3'd0,1,0,0,0,3'd0,3'd7, 1,3'd0,8'hAB,0,0,0,16'd7,1};
      vecs[14] = '{0,0,8'h00,1,1,1,3'd0,1,1,0,0,3'd0,3'd0, 0,3'd0,8'hAB,0,0,0,16'd7,0};
      drive(vecs[0]);
      @(posedge clk);
      for (int i = 0; i < 15; i++) begin
         #1 drive(vecs[i]);
         sb_q.push_back(vecs[i]);
         @(posedge clk);
         #1 compare(i);
      end
      // run the counter up to its top value, then across the wrap
      ex_valid = 1'b1; ex_reg_wr = 1'b0; ex_flag_wr = 1'b0; stall = 1'b0; flush = 1'b0; reset = 1'b0;
      for (int i = 0; i < 65528; i++) @(posedge clk);
      #1 check("retired_top", 100, retired, 16'hFFFF);
      @(posedge clk);
      #1 check("retired_wrap", 101, retired, 16'h0000);
      ex_valid = 1'b0;
      @(posedge clk);
      #1 check("retired_hold", 102, retired, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
